// File: rtl/gray2bin_sched.sv
// Round-robin scheduler sharing one registered gray-to-binary converter; accept-to-rsp_valid is 3 edges, 4 cycles/txn min.
// One transaction in flight: requesters wait while busy, and a stalled rsp_ready holds the response and blocks new grants.
module gray2bin_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_gray,
  output logic [N_REQ-1:0]   req_ready,
  output logic               conv_rst,
  output logic [W-1:0]       conv_gray,
  input  logic [W-1:0]       conv_bin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_bin,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] win;
  logic           win_vld;
  logic           rst_arm;
  logic [W-1:0]   gray_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) gray_arr[i] = req_gray[i*W +: W];
  end

  // First valid requester at or above ptr, wrapping modulo N_REQ (works for non-power-of-two N_REQ).
  always_comb begin : arb
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      cand = sum[IDW-1:0];
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !conv_rst && win_vld) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id_reg    <= '0;
      conv_gray <= '0;
      rsp_valid <= 1'b0;
      rsp_bin   <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      conv_rst  <= 1'b1;
      rst_arm   <= 1'b0;
    end else begin
      // conv_rst drops on the second edge after release so the converter sees a reset edge.
      rst_arm <= 1'b1;
      if (rst_arm) conv_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (!conv_rst && win_vld) begin
            conv_gray <= gray_arr[win];
            id_reg    <= win;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_bin   <= conv_bin;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= (id_reg == IDW'(N_REQ-1)) ? '0 : id_reg + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray2bin_sched.sv
// Self-checking bench for gray2bin_sched with a registered converter model and a round-robin reference model.
module tb_gray2bin_sched;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_gray = '0;
  logic [N-1:0]   req_ready;
  logic           conv_rst;
  logic [W-1:0]   conv_gray;
  logic [W-1:0]   conv_bin;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_bin;
  logic [1:0]     rsp_id;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mptr = 0;
  logic [W-1:0] codes [N];

  gray2bin_sched #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .conv_rst(conv_rst), .conv_gray(conv_gray),
    .conv_bin(conv_bin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bin(rsp_bin), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // binary bit i is the XOR of all gray bits at or above i
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  // external converter: registered, synchronous active-high reset
  always_ff @(posedge clk) conv_bin <= conv_rst ? '0 : g2b(conv_gray);

  task automatic load_codes(input bit distinct);
    int base;
    base = $urandom_range(0, 15);
    for (int i = 0; i < N; i++) begin
      codes[i] = distinct ? 4'(base + 5 * i) : 4'($urandom_range(0, 15));
      req_gray[i*W +: W] = codes[i];
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clk); #1;
      ok = (rsp_valid === 1'b1);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; #1;
    mptr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    load_codes(1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, busy, conv_gray, rsp_bin, rsp_id} !== '0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", {rsp_valid, busy, conv_gray, rsp_bin, rsp_id}); end
    checks++; if (conv_rst !== 1'b1) begin failures++; $display("FAIL reset_conv_rst got=%0b exp=1", conv_rst); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (conv_rst !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL rel_edge1 got conv_rst=%0b req_ready=%b exp 1/0000", conv_rst, req_ready); end
    @(posedge clk); #1;
    checks++; if (conv_rst !== 1'b0 || req_ready !== 4'b0001) begin failures++; $display("FAIL rel_edge2 got conv_rst=%0b req_ready=%b exp 0/0001", conv_rst, req_ready); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rel_accept_busy got=%0b exp=1", busy); end
    req_valid = '0;
    wait_rsp(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rel_rsp timeout exp rsp_valid=1"); end
    else if (rsp_id !== 2'd0 || rsp_bin !== g2b(codes[0])) begin failures++; $display("FAIL rel_rsp got id=%0d bin=%b exp id=0 bin=%b", rsp_id, rsp_bin, g2b(codes[0])); end
    @(posedge clk); #1;
    mptr = 1;
  endtask

  task automatic test_single();
    load_codes(1'b0);
    codes[2] = 4'b1011;
    req_gray[2*W +: W] = 4'b1011;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_pulse got=%b exp=0000", req_ready); end
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_rsp got=%0b exp=0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, rsp_bin, rsp_id} !== {1'b1, 4'b1101, 2'd2}) begin failures++; $display("FAIL single_rsp got v=%0b bin=%b id=%0d exp v=1 bin=1101 id=2", rsp_valid, rsp_bin, rsp_id); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got v=%0b busy=%0b exp 0/0", rsp_valid, busy); end
    mptr = 3;
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp, prev;
    load_codes(1'b1);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    apply_reset();
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      exp = winner(4'b1111, mptr);
      wait_rsp(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rr_timeout k=%0d exp rsp_valid=1", k); end
      else if (rsp_id !== 2'(exp) || rsp_bin !== g2b(codes[exp])) begin failures++; $display("FAIL rr_rsp k=%0d got id=%0d bin=%b exp id=%0d bin=%b", k, rsp_id, rsp_bin, exp, g2b(codes[exp])); end
      if (prev >= 0) begin
        checks++; if (cyc - prev != 4) begin failures++; $display("FAIL rr_spacing k=%0d got=%0d exp=4", k, cyc - prev); end
      end
      prev = cyc;
      mptr = (exp + 1) % N;
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int exp;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    exp = winner(4'b1111, mptr);
    wait_rsp(ok);
    checks++; if (!ok || rsp_id !== 2'(exp)) begin failures++; $display("FAIL bp_rsp got v=%0b id=%0d exp v=1 id=%0d", rsp_valid, rsp_id, exp); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, rsp_id, rsp_bin} !== {1'b1, 2'(exp), g2b(codes[exp])}) begin failures++; $display("FAIL bp_hold c=%0d got v=%0b id=%0d bin=%b exp v=1 id=%0d bin=%b", c, rsp_valid, rsp_id, rsp_bin, exp, g2b(codes[exp])); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_grant c=%0d got=%b exp=0000", c, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", rsp_valid); end
    mptr = (exp + 1) % N;
    checks++; if (req_ready !== 4'(1 << mptr)) begin failures++; $display("FAIL bp_next_grant got=%b exp=%b", req_ready, 4'(1 << mptr)); end
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_no_grant got busy=%0b exp=0", busy); end
  endtask

  task automatic test_ptr_skip();
    bit ok;
    int exp;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    wait_rsp(ok);
    checks++; if (!ok || rsp_id !== 2'd2) begin failures++; $display("FAIL skip_setup got v=%0b id=%0d exp v=1 id=2", rsp_valid, rsp_id); end
    req_valid = '0;
    @(posedge clk); #1;
    mptr = 3;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL skip_grant got=%b exp=0010", req_ready); end
    wait_rsp(ok);
    checks++; if (!ok || rsp_id !== 2'd1 || rsp_bin !== g2b(codes[1])) begin failures++; $display("FAIL skip_rsp got v=%0b id=%0d bin=%b exp v=1 id=1 bin=%b", rsp_valid, rsp_id, rsp_bin, g2b(codes[1])); end
    req_valid = '0;
    @(posedge clk); #1;
    mptr = 2;
    req_valid = 4'b1101;
    exp = winner(4'b1101, mptr);
    #1;
    checks++; if (req_ready !== 4'(1 << exp)) begin failures++; $display("FAIL skip_next_search got=%b exp=%b", req_ready, 4'(1 << exp)); end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok, done, rdy;
    int exp;
    logic [N-1:0] mask;
    for (int t = 0; t < 12; t++) begin
      load_codes(1'b0);
      mask = 4'($urandom_range(1, 15));
      req_valid = mask;
      rsp_ready = 1'($urandom_range(0, 1));
      exp = winner(mask, mptr);
      wait_rsp(ok);
      req_valid = '0;
      checks++;
      if (!ok) begin failures++; $display("FAIL rnd_timeout t=%0d exp rsp_valid=1", t); end
      else if (rsp_id !== 2'(exp) || rsp_bin !== g2b(codes[exp])) begin failures++; $display("FAIL rnd_rsp t=%0d got id=%0d bin=%b exp id=%0d bin=%b", t, rsp_id, rsp_bin, exp, g2b(codes[exp])); end
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        rdy = (c == 39) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp_ready = rdy;
        @(posedge clk); #1;
        checks++;
        if (rdy) begin
          done = 1'b1;
          if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rnd_handshake t=%0d got v=%0b exp=0", t, rsp_valid); end
        end else if ({rsp_valid, rsp_id, rsp_bin} !== {1'b1, 2'(exp), g2b(codes[exp])}) begin
          failures++; $display("FAIL rnd_hold t=%0d got v=%0b id=%0d bin=%b exp v=1 id=%0d", t, rsp_valid, rsp_id, rsp_bin, exp);
        end
      end
      mptr = (exp + 1) % N;
    end
  endtask

  task automatic test_midop_reset();
    bit seen;
    load_codes(1'b0);
    codes[0] = 4'($urandom_range(1, 15));
    req_gray[0 +: W] = codes[0];
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || conv_gray !== codes[0]) begin failures++; $display("FAIL mid_inflight got busy=%0b gray=%b exp 1/%b", busy, conv_gray, codes[0]); end
    #1 rst_n = 1'b0;
    #1;
    mptr = 0;
    checks++; if ({rsp_valid, busy, conv_gray, rsp_bin, rsp_id} !== '0) begin failures++; $display("FAIL mid_reset_outputs got=%0h exp=0", {rsp_valid, busy, conv_gray, rsp_bin, rsp_id}); end
    checks++; if (conv_rst !== 1'b1) begin failures++; $display("FAIL mid_conv_rst got=%0b exp=1", conv_rst); end
    req_valid = 4'b1111;
    repeat (2) begin @(posedge clk); #1; seen |= (rsp_valid !== 1'b0); end
    rst_n = 1'b1;
    @(posedge clk); #1; seen |= (rsp_valid !== 1'b0);
    checks++; if (conv_rst !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL mid_rel_edge1 got conv_rst=%0b req_ready=%b exp 1/0000", conv_rst, req_ready); end
    @(posedge clk); #1; seen |= (rsp_valid !== 1'b0);
    checks++; if (conv_rst !== 1'b0 || req_ready !== 4'b0001) begin failures++; $display("FAIL mid_rel_edge2 got conv_rst=%0b req_ready=%b exp 0/0001", conv_rst, req_ready); end
    checks++; if (seen) begin failures++; $display("FAIL mid_no_rsp got rsp_valid pulse exp none"); end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_ptr_skip();
    test_random();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray2bin_sched.md
Name: gray2bin_sched

Overview:
- Round-robin scheduler sharing one registered 4-bit gray-to-binary converter among N_REQ requesters.
- Accepts gray codes over per-requester valid/ready handshakes and sequences the converter. The converter is external: registered, 1-cycle latency, synchronous active-high reset.
- Returns each binary result with the ID of the requester that issued it.
- Owns the converter's reset sequencing.

Parameters:
- N_REQ, 4: number of requesters. Legal range is 1..16.
- W, 4: gray/binary code width. Must match the converter width.
- IDW, max(1, clog2(N_REQ)): width of the requester ID. Derived, not overridable.

Ports:
- clk  in  1  — system clock, rising edge.
- rst_n  in  1  — reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  — per-requester request valid.
- req_gray  in  N_REQ*W  — requester i's gray code on [i*W +: W].
- req_ready  out  N_REQ  — one-hot accept strobe. Combinational.
- conv_rst  out  1  — reset to the converter, active-high.
- conv_gray  out  W  — registered gray code driven to the converter input.
- conv_bin  in  W  — converter binary output, valid 1 cycle after conv_gray is sampled.
- rsp_valid  out  1  — result valid.
- rsp_ready  in  1  — result consumer ready.
- rsp_bin  out  W  — binary result.
- rsp_id  out  IDW  — ID of the requester that issued the result.
- busy  out  1  — high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, ptr = 0.
  - conv_gray = 0, rsp_valid = 0, rsp_bin = 0, rsp_id = 0, busy = 0.
  - req_ready = 0, conv_rst = 1.
- Converter reset sequencing:
  - conv_rst is set asynchronously by rst_n low.
  - It clears synchronously on the 2nd rising clk edge after rst_n deasserts, so the converter sees at least one reset edge.
  - No request is accepted while conv_rst = 1.
- States: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - When conv_rst = 0 and req_valid != 0, the winner is the first set req_valid bit searching upward from ptr, wrapping modulo N_REQ.
  - req_ready[winner] = 1 in that same cycle; all other req_ready bits are 0. The handshake completes on that edge.
  - On that edge: conv_gray <= req_gray[winner], id_reg <= winner, go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: conv_gray held stable. The converter samples it at this cycle's closing edge. Unconditionally go to CAPTURE.
- CAPTURE: conv_bin is now valid. On this edge: rsp_bin <= conv_bin, rsp_id <= id_reg, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_bin and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid <= 0, ptr <= (id_reg + 1) mod N_REQ, go to IDLE.
- conv_gray holds its last value outside IDLE-accept edges.
- rsp_bin and rsp_id hold their last values after the handshake.
- Latency: request accepted at edge E gives rsp_valid = 1 after edge E+2 (3rd cycle after accept). Minimum 4 cycles per transaction with rsp_ready tied high.
- Boundary conditions:
  - Only one transaction is in flight at a time. Requests arriving while busy wait.
  - A requester may drop req_valid before being granted; nothing is recorded.
  - Requesters must hold req_gray stable while req_valid = 1 until granted.
  - rsp_ready while rsp_valid = 0 is ignored.
  - N_REQ = 1: the arbiter degenerates to pass-through and ptr stays 0.
  - Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. Each waits at most N_REQ-1 transactions.
  - ptr updates only on response completion, not on grant.
  - rst_n asserted mid-transaction aborts it with no response emitted. conv_rst re-runs its sequence.
- Arithmetic: ID wrap uses modulo N_REQ, including non-power-of-two N_REQ. rsp_bin is conv_bin unmodified; the scheduler does no conversion math.

Test Plan:
1. Reset release: rst_n low for 3 cycles then high, req_valid = 4'b0001 held.
   - conv_rst = 1 until the 2nd edge after release.
   - req_ready[0] first pulses the cycle after conv_rst falls.
2. Single request: requester 2 sends gray 4'b1011, rsp_ready = 1.
   - Bench converter is a correct registered model.
   - rsp_valid rises 3 cycles after accept with rsp_bin = 4'b1101, rsp_id = 2.
   - req_ready = 4'b0100 for exactly one cycle.
3. Round-robin: all four req_valid held high, each with a distinct code, e.g. gray 4'b0110 -> 4'b0100.
   - rsp_id sequence 0,1,2,3,0.
   - One response every 4 cycles, each rsp_bin correct.
4. Backpressure: rsp_ready low for 5 cycles in RESP.
   - rsp_valid, rsp_bin and rsp_id stable.
   - No req_ready pulse.
   - Handshake completes on the first cycle rsp_ready = 1.
5. Pointer skip: ptr = 3, only requester 1 valid.
   - Requester 1 granted.
   - Next grant search starts at 2.
6. Mid-op reset: assert rst_n in the CAPTURE state.
   - All outputs go to reset values immediately.
   - No rsp_valid pulse for the aborted request.
   - conv_rst sequence repeats.
